// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard for the ID stage.
// Produces stall and forwarding selects from the tracked writers.
module hazard_scoreboard #(
  parameter int NREG      = 32,
  parameter int DEPTH     = 3,
  parameter int LOAD_RDY  = 2,
  parameter int FWD_EN    = 1,
  parameter int WB_BYPASS = 1,
  localparam int AW = $clog2(NREG),
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [AW-1:0] id_rd,
  input  logic          id_regwr,
  input  logic          id_load,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] fwd_a,
  output logic [SW-1:0] fwd_b,
  output logic [SW-1:0] inflight,
  output logic [15:0]   stall_cnt
);

  logic [DEPTH-1:0] e_valid;
  logic [DEPTH-1:0] e_regwr;
  logic [DEPTH-1:0] e_load;
  logic [AW-1:0]    e_rd [DEPTH];

  logic [DEPTH-1:0] live;
  logic             take;
  logic             stl_a;
  logic             stl_b;
  logic [SW-1:0]    sel_a;
  logic [SW-1:0]    sel_b;
  logic [SW-1:0]    cnt;

  // A flushed entry 0 is already dead: it neither matches nor counts.
  always_comb begin
    live = e_valid & e_regwr;
    if (flush) live[0] = 1'b0;
  end

  assign take = id_valid & ~stall & ~flush;

  function automatic logic [SW:0] lookup(
    input logic [AW-1:0]    src,
    input logic             used,
    input logic [DEPTH-1:0] lv
  );
    logic          hit;
    int            k_hit;
    logic          stl;
    logic [SW-1:0] sel;
    hit   = 1'b0;
    k_hit = 0;
    stl   = 1'b0;
    sel   = '0;
    // Descending scan leaves the youngest writer in k_hit.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (lv[k] && e_rd[k] == src) begin
        hit   = 1'b1;
        k_hit = k;
      end
    end
    if (!(id_valid && used && src != '0)) hit = 1'b0;
    if (WB_BYPASS != 0 && k_hit == DEPTH - 1) hit = 1'b0;
    if (hit) begin
      if (FWD_EN == 0) begin
        stl = 1'b1;
      end else if (e_load[k_hit] && k_hit < LOAD_RDY) begin
        stl = 1'b1;
      end else begin
        sel = SW'(k_hit + 1);
      end
    end
    return {stl, sel};
  endfunction

  always_comb begin
    {stl_a, sel_a} = lookup(id_rs, id_rs_used, live);
    {stl_b, sel_b} = lookup(id_rt, id_rt_used, live);
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + SW'(live[k]);
    end
  end

  assign stall    = (stl_a | stl_b) & ~flush & ~rst;
  assign fwd_a    = rst ? '0 : sel_a;
  assign fwd_b    = rst ? '0 : sel_b;
  assign inflight = rst ? '0 : cnt;

  always_ff @(negedge clk) begin
    if (rst) begin
      e_valid   <= '0;
      e_regwr   <= '0;
      e_load    <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        e_rd[k] <= '0;
      end
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        e_valid[k] <= e_valid[k-1];
        e_regwr[k] <= e_regwr[k-1];
        e_load[k]  <= e_load[k-1];
        e_rd[k]    <= e_rd[k-1];
      end
      if (flush) e_valid[1] <= 1'b0;
      e_valid[0] <= take;
      e_regwr[0] <= id_regwr;
      e_load[0]  <= id_load;
      e_rd[0]    <= id_rd;
      if (stall && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
